// File: rtl/bn254_fp_final_reduce.sv
// Final reduction of the Montgomery multiplier output. It takes an unreduced value below 8*Mod
// and returns the canonical residue in [0, Mod). It conditionally subtracts 4*Mod, 2*Mod and
// Mod, then runs a non-committing check against Mod. Each pass is a borrow-chained subtraction
// done one chunk per cycle.
module bn254_fp_final_reduce #(
   parameter int unsigned WIDTH   = 289,
   parameter int unsigned CHUNKS  = 4,
   parameter int unsigned CHUNK_W = 73,
   parameter logic [255:0] MOD    =
      256'h2523648240000001ba344d80000000086121000000000013a700000000000013
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_x,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [255:0]     o_z,
   output logic             o_err
);

   localparam int unsigned ACC_W = CHUNKS * CHUNK_W;
   localparam int unsigned CIW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   localparam logic [ACC_W-1:0] MOD_X1 = ACC_W'(MOD);
   localparam logic [ACC_W-1:0] MOD_X2 = MOD_X1 << 1;
   localparam logic [ACC_W-1:0] MOD_X4 = MOD_X1 << 2;

   typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_tmp;
   logic [1:0]         r_pass;
   logic [CIW-1:0]     r_chunk;
   logic               r_borrow;
   logic               r_err;

   int unsigned        w_base;
   logic [ACC_W-1:0]   w_sub_full;
   logic [CHUNK_W-1:0] w_acc_c;
   logic [CHUNK_W-1:0] w_sub_c;
   logic [CHUNK_W:0]   w_diff;
   logic               w_b;
   logic               w_last;
   logic [ACC_W-1:0]   w_tmp_full;

   // Per-chunk borrow-chained subtraction. The current difference is merged into tmp, so the
   // final chunk can commit the whole word on the same edge.
   always_comb begin
      w_base = 32'(r_chunk) * CHUNK_W;
      case (r_pass)
         2'd0:    w_sub_full = MOD_X4;
         2'd1:    w_sub_full = MOD_X2;
         default: w_sub_full = MOD_X1;
      endcase
      w_acc_c    = r_acc[w_base +: CHUNK_W];
      w_sub_c    = w_sub_full[w_base +: CHUNK_W];
      w_diff     = {1'b0, w_acc_c} - {1'b0, w_sub_c} - (CHUNK_W + 1)'(r_borrow);
      w_b        = w_diff[CHUNK_W];
      w_last     = (r_chunk == CIW'(CHUNKS - 1));
      w_tmp_full = r_tmp;
      w_tmp_full[w_base +: CHUNK_W] = w_diff[CHUNK_W-1:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic: accept in idle, 4 passes of CHUNKS cycles, hold result until taken.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: if (i_valid) w_state_nxt = StSub;
         StSub:  if (w_last && (r_pass == 2'd3)) w_state_nxt = StDone;
         StDone: if (i_ready) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Datapath: load on accept, step one chunk per cycle, commit only on borrow-free passes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_tmp    <= '0;
         r_pass   <= '0;
         r_chunk  <= '0;
         r_borrow <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_valid) begin
                  r_acc    <= ACC_W'(i_x);
                  r_pass   <= '0;
                  r_chunk  <= '0;
                  r_borrow <= 1'b0;
               end
            end
            StSub: begin
               r_tmp <= w_tmp_full;
               if (w_last) begin
                  r_borrow <= 1'b0;
                  r_chunk  <= '0;
                  r_pass   <= r_pass + 2'd1;
                  // The last pass only checks the range; no borrow means the value is still >= Mod.
                  if (r_pass == 2'd3) r_err <= ~w_b;
                  else if (!w_b)      r_acc <= w_tmp_full;
               end else begin
                  r_borrow <= w_b;
                  r_chunk  <= r_chunk + CIW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready = (r_state == StIdle);
   assign o_valid = (r_state == StDone);
   assign o_z     = r_acc[255:0];
   assign o_err   = r_err;

endmodule

// File: tb/tb_bn254_fp_final_reduce.sv
// Testbench for bn254_fp_final_reduce. It runs table vectors, random values against an
// arithmetic model, backpressure, an input pulse while busy, and a mid-operation reset.
module tb_bn254_fp_final_reduce;

   localparam logic [255:0] MOD =
      256'h2523648240000001ba344d80000000086121000000000013a700000000000013;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [288:0] i_x = '0;
   logic         o_valid;
   logic         i_ready = 1'b0;
   logic [255:0] o_z;
   logic         o_err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bn254_fp_final_reduce dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_x     (i_x),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_z     (o_z),
      .o_err   (o_err)
   );

   typedef struct {
      string        name;
      logic [291:0] x;
      logic [255:0] z;
      logic         err;
      logic         chk_z;
   } vec_t;

   task automatic check(input string name, input logic [291:0] act, input logic [291:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Apply one value, check latency, result, optional hold stability and the handshake.
   task automatic run(input string name, input logic [291:0] x, input logic [255:0] z,
                      input logic err, input logic chk_z, input int hold, input bit pulse);
      int n;
      logic [255:0] z0;
      logic e0;
      @(negedge clk);
      check({name, " ready"}, 292'(o_ready), 292'(1));
      i_x = x[288:0];
      i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
         if (pulse && n == 3) begin
            i_valid = 1'b1;
            i_x = '1;
         end
         if (pulse && n == 5) i_valid = 1'b0;
      end
      check({name, " latency"}, 292'(n), 292'(16));
      if (!o_valid) begin
         i_ready = 1'b1;
         return;
      end
      if (chk_z) check({name, " z"}, 292'(o_z), 292'(z));
      check({name, " err"}, 292'(o_err), 292'(err));
      z0 = o_z;
      e0 = o_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({name, " hold valid"}, 292'(o_valid), 292'(1));
         check({name, " hold ready"}, 292'(o_ready), 292'(0));
         check({name, " hold z"}, 292'(o_z), 292'(z0));
         check({name, " hold err"}, 292'(o_err), 292'(e0));
      end
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1 i_ready = 1'b0;
      check({name, " ready after hs"}, 292'(o_ready), 292'(1));
      check({name, " valid after hs"}, 292'(o_valid), 292'(0));
   endtask

   initial begin
      logic [291:0] m;
      logic [291:0] r;
      logic [291:0] x;
      logic [291:0] one;
      vec_t vecs[$];
      int n;

      m   = 292'(MOD);
      one = 292'(1);
      vecs.push_back('{"zero",     292'(0),              256'(0),      1'b0, 1'b1});
      vecs.push_back('{"mod",      m,                    256'(0),      1'b0, 1'b1});
      vecs.push_back('{"8m-1",     m * 8 - 1,            MOD - 1,      1'b0, 1'b1});
      vecs.push_back('{"5m+7",     m * 5 + 7,            256'(7),      1'b0, 1'b1});
      vecs.push_back('{"8m",       m * 8,                256'(0),      1'b1, 1'b0});
      vecs.push_back('{"all1",     (one << 289) - 1,     256'(0),      1'b1, 1'b0});
      vecs.push_back('{"borrow73", m + (one << 73) - 1,  256'((one << 73) - 1), 1'b0, 1'b1});
      vecs.push_back('{"7m+5",     m * 7 + 5,            256'(5),      1'b0, 1'b1});

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst ready", 292'(o_ready), 292'(1));
      check("rst valid", 292'(o_valid), 292'(0));
      check("rst z", 292'(o_z), 292'(0));
      check("rst err", 292'(o_err), 292'(0));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         run(vecs[i].name, vecs[i].x, vecs[i].z, vecs[i].err, vecs[i].chk_z, 0, 1'b0);

      // Backpressure, then an input pulse while busy.
      run("hold", m * 6 + 123, 256'(123), 1'b0, 1'b1, 5, 1'b0);
      run("pulse", m * 5 + 7, 256'(7), 1'b0, 1'b1, 0, 1'b1);
      repeat (3) @(posedge clk);
      #1 check("pulse no extra", 292'(o_valid), 292'(0));

      // Random values against the arithmetic model.
      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < 10; k++) r[k*32 +: 32] = 32'($urandom());
         r[291:289] = 3'b000;
         if (t % 4 == 3) x = r;
         else            x = r % (m * 8);
         run($sformatf("rand%0d", t), x, 256'(x % m), (x >= m * 8), (x < m * 8), 0, 1'b0);
      end

      // Reset at pass 1, chunk 2 (after edge E6).
      @(negedge clk);
      i_x = 289'(m * 7 + 5);
      i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst ready", 292'(o_ready), 292'(1));
      check("midrst valid", 292'(o_valid), 292'(0));
      check("midrst z", 292'(o_z), 292'(0));
      check("midrst err", 292'(o_err), 292'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run("after rst", m * 3 + 1, 256'(1), 1'b0, 1'b1, 0, 1'b0);

      n = n_cmp;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, n_fail);
      $finish;
   end

endmodule
